// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD timing controller.
// Bit positions refer to the core's memory-mapped LCD register word.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_PWR,
        S_IDLE,
        S_SETUP,
        S_EN,
        S_HOLD,
        S_WAIT
    } lcd_state_e;

    localparam int LCD_ON_BIT   = 31;
    localparam int LCD_TGL_BIT  = 10;
    localparam int LCD_RS_BIT   = 9;
    localparam int LCD_DATA_MSB = 7;

    localparam logic [7:0] LCD_CLR  = 8'h01;
    localparam logic [7:0] LCD_HOME = 8'h02;

    // Clear and return-home (0x01..0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == LCD_CLR || data == LCD_HOME || data == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_fifo.sv
// Small synchronous FIFO holding queued {RS, DATA} LCD commands.
// Read data is the current head; a pop on a full queue frees room for a same-cycle push.
module lcd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr;
    logic             rd;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780-class LCD timing controller: detects command toggles from the core
// register, queues them, and replays each with setup/enable/hold/execution timing.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_PWR_CYC   = 750000,
    parameter int T_SETUP_CYC = 4,
    parameter int T_EN_CYC    = 25,
    parameter int T_HOLD_CYC  = 2,
    parameter int T_CMD_CYC   = 2500,
    parameter int T_CLR_CYC   = 82000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [31:0]                   i_lcd_word,
    output logic [7:0]                    o_lcd_data,
    output logic                          o_lcd_rs,
    output logic                          o_lcd_rw,
    output logic                          o_lcd_en,
    output logic                          o_lcd_on,
    output logic                          o_busy,
    output logic                          o_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt
);

    localparam int MAX_A = (T_PWR_CYC > T_CLR_CYC) ? T_PWR_CYC : T_CLR_CYC;
    localparam int MAX_B = (T_CMD_CYC > T_EN_CYC) ? T_CMD_CYC : T_EN_CYC;
    localparam int MAX_C = (T_SETUP_CYC > T_HOLD_CYC) ? T_SETUP_CYC : T_HOLD_CYC;
    localparam int MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_T = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int CNT_W = ($clog2(MAX_T + 1) > 20) ? $clog2(MAX_T + 1) : 20;

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             prev_tgl;
    logic             on_q;
    logic             ovf_q;

    logic             push;
    logic             pop;
    logic [8:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             unused_word_bits;

    assign unused_word_bits = ^{i_lcd_word[30:11], i_lcd_word[8]};

    assign push = !i_reset && (i_lcd_word[LCD_TGL_BIT] != prev_tgl);

    lcd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk   (i_clk),
        .reset (i_reset),
        .push  (push),
        .pop   (pop),
        .wdata ({i_lcd_word[LCD_RS_BIT], i_lcd_word[LCD_DATA_MSB:0]}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_fifo_cnt)
    );

    // Loading prev_tgl during reset swallows whatever toggle level firmware left behind.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prev_tgl <= i_lcd_word[LCD_TGL_BIT];
            on_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            prev_tgl <= i_lcd_word[LCD_TGL_BIT];
            on_q     <= i_lcd_word[LCD_ON_BIT];
            if (push && fifo_full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_PWR;
            cnt_q   <= CNT_W'(T_PWR_CYC);
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    // The shared counter is reloaded on every state entry; a state ends when it reaches 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        rs_d    = rs_q;
        data_d  = data_q;
        pop     = 1'b0;
        case (state_q)
            S_PWR: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    rs_d    = fifo_rdata[8];
                    data_d  = fifo_rdata[7:0];
                    state_d = S_SETUP;
                    cnt_d   = CNT_W'(T_SETUP_CYC);
                end
            end
            S_SETUP: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_EN;
                    en_d    = 1'b1;
                    cnt_d   = CNT_W'(T_EN_CYC);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_EN: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_HOLD;
                    en_d    = 1'b0;
                    cnt_d   = CNT_W'(T_HOLD_CYC);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_WAIT;
                    cnt_d   = is_long_cmd(rs_q, data_q) ? CNT_W'(T_CLR_CYC)
                                                        : CNT_W'(T_CMD_CYC);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_PWR;
                cnt_d   = CNT_W'(T_PWR_CYC);
                en_d    = 1'b0;
            end
        endcase
    end

    assign o_lcd_data = data_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = en_q;
    assign o_lcd_on   = on_q;
    assign o_ovf      = ovf_q;
    assign o_busy     = (state_q != S_IDLE) || (cnt_q != '0) || !fifo_empty;

endmodule
